stream_reader: RTL

- Reads host/card memory regions supplied via mem_config into a normalized AXI4S output stream.
- Uses FPGA-initiated reads: chunked requests on sq_rd, data returned on input_data, acknowledgements on cq_rd.
- Raises a notify interrupt after each region is fully consumed and acknowledged, so the host can supply the next region.
- Sits between the Coyote read path and operator inputs. It is the read-side counterpart of StreamWriter.

---
 rtl/stream_reader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_reader.sv
// Turns host/card memory regions into a normalized AXI4S stream: issues chunked read requests,
// reshapes returned data (keep/last) per region, and raises a notify once a region is consumed.
module stream_reader #(
    parameter logic [1:0] STRM                  = 2'd1,
    parameter int         AXI_STRM_ID           = 0,
    parameter bit         IS_LOCAL              = 1'b1,
    parameter int         TRANSFER_LENGTH_BYTES = 4096,
    parameter int         MAX_OUTSTANDING       = 4,
    parameter int         AXI_DATA_BITS         = 512,
    parameter int         VADDR_BITS            = 48,
    parameter int         LEN_BITS              = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // All channels are valid/ready: a transfer happens on a rising edge where both are high.
    output logic                         sq_rd_valid,
    input  logic                         sq_rd_ready,
    output logic [4:0]                   sq_rd_opcode,
    output logic [1:0]                   sq_rd_strm,
    output logic                         sq_rd_mode,
    output logic                         sq_rd_rdma,
    output logic                         sq_rd_remote,
    output logic [VADDR_BITS-1:0]        sq_rd_vaddr,
    output logic [LEN_BITS-1:0]          sq_rd_len,
    output logic [5:0]                   sq_rd_pid,
    output logic [3:0]                   sq_rd_dest,
    output logic                         sq_rd_last,
    input  logic                         cq_rd_valid,
    output logic                         cq_rd_ready,
    input  logic [1:0]                   cq_rd_strm,
    input  logic [3:0]                   cq_rd_dest,
    output logic                         notify_valid,
    input  logic                         notify_ready,
    output logic [5:0]                   notify_pid,
    output logic [31:0]                  notify_value,
    input  logic                         mem_config_valid,
    output logic                         mem_config_ready,
    input  logic [VADDR_BITS-1:0]        mem_config_vaddr,
    input  logic [VADDR_BITS-1:0]        mem_config_size,
    input  logic                         input_data_tvalid,
    output logic                         input_data_tready,
    input  logic [AXI_DATA_BITS-1:0]     input_data_tdata,
    output logic                         output_data_tvalid,
    input  logic                         output_data_tready,
    output logic [AXI_DATA_BITS-1:0]     output_data_tdata,
    output logic [AXI_DATA_BITS/8-1:0]   output_data_tkeep,
    output logic                         output_data_tlast,
    output logic [1:0]                   state_dbg
);
    localparam int BYTES      = AXI_DATA_BITS / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam logic [4:0] OPC_LOCAL_READ = 5'h00;
    localparam logic [4:0] OPC_RDMA_READ  = 5'h0c;

    if (TRANSFER_LENGTH_BYTES % BYTES != 0) begin : g_bad_transfer
        $error("TRANSFER_LENGTH_BYTES must be a multiple of the data bus width in bytes");
    end
    if (AXI_STRM_ID < 0 || AXI_STRM_ID > 7) begin : g_bad_id
        $error("AXI_STRM_ID must be in 0..7");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING must be in 1..16");
    end

    typedef enum logic [1:0] {WAIT_BUFFER, REQUEST, WAIT_COMPLETION, NOTIFY} state_t;
    state_t state, state_next;

    logic                  armed;
    logic [VADDR_BITS-1:0] vaddr, bytes_left, emit_left, num_requests, num_completed;
    logic [27:0]           bytes_in_region;
    logic [LEN_BITS-1:0]   len_fifo [16];
    logic [3:0]            wr_ptr, rd_ptr;
    logic [4:0]            outstanding;
    logic [LEN_BITS-1:0]   beat_cnt, req_len, head_len, beats_expected;
    logic                  buf_hs, sq_hs, in_hs, req_done, cq_hit, region_done, region_last;
    logic [AXI_DATA_BITS/8-1:0] beat_keep;
    logic [BYTE_SHIFT-1:0] tail_bytes;

    assign buf_hs      = mem_config_valid && mem_config_ready;
    assign sq_hs       = sq_rd_valid && sq_rd_ready;
    assign in_hs       = input_data_tvalid && input_data_tready;
    assign req_len     = (bytes_left < VADDR_BITS'(TRANSFER_LENGTH_BYTES)) ?
                         bytes_left[LEN_BITS-1:0] : LEN_BITS'(TRANSFER_LENGTH_BYTES);
    assign head_len       = len_fifo[rd_ptr];
    assign beats_expected = (head_len + LEN_BITS'(BYTES - 1)) >> BYTE_SHIFT;
    assign req_done    = in_hs && (beat_cnt + LEN_BITS'(1) == beats_expected);
    assign cq_hit      = cq_rd_valid && (cq_rd_strm == STRM) && (cq_rd_dest == 4'(AXI_STRM_ID));
    assign region_done = (num_completed == num_requests) && (outstanding == 5'd0);

    // The region's final beat is identified by the bytes still to be emitted, not by request boundaries.
    assign region_last = emit_left <= VADDR_BITS'(BYTES);
    assign tail_bytes  = emit_left[BYTE_SHIFT-1:0];
    always_comb begin
        beat_keep = '1;
        if (region_last && tail_bytes != '0) beat_keep = ~({(AXI_DATA_BITS/8){1'b1}} << tail_bytes);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_BUFFER;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_BUFFER:     if (buf_hs) state_next = (mem_config_size == '0) ? NOTIFY : REQUEST;
            REQUEST:         if (sq_hs && bytes_left == VADDR_BITS'(req_len)) state_next = WAIT_COMPLETION;
            WAIT_COMPLETION: if (region_done) state_next = notify_ready ? WAIT_BUFFER : NOTIFY;
            NOTIFY:          if (notify_ready) state_next = WAIT_BUFFER;
            default:         state_next = WAIT_BUFFER;
        endcase
    end

    always_comb begin
        mem_config_ready = armed && (state == WAIT_BUFFER);
        sq_rd_valid      = (state == REQUEST) && (outstanding < 5'(MAX_OUTSTANDING));
        notify_valid     = (state == NOTIFY) || ((state == WAIT_COMPLETION) && region_done);
    end

    assign state_dbg    = state;
    assign sq_rd_opcode = IS_LOCAL ? OPC_LOCAL_READ : OPC_RDMA_READ;
    assign sq_rd_strm   = STRM;
    assign sq_rd_mode   = !IS_LOCAL;
    assign sq_rd_rdma   = !IS_LOCAL;
    assign sq_rd_remote = !IS_LOCAL;
    assign sq_rd_vaddr  = vaddr;
    assign sq_rd_len    = req_len;
    assign sq_rd_pid    = 6'd0;
    assign sq_rd_dest   = 4'(AXI_STRM_ID);
    assign sq_rd_last   = 1'b1;
    assign cq_rd_ready  = 1'b1;
    assign notify_pid   = 6'd0;
    assign notify_value = {1'b1, bytes_in_region, 3'(AXI_STRM_ID)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed           <= 1'b0;
            vaddr           <= '0;
            bytes_left      <= '0;
            emit_left       <= '0;
            bytes_in_region <= '0;
            num_requests    <= '0;
            num_completed   <= '0;
        end else begin
            armed <= 1'b1;
            if (buf_hs) begin
                vaddr           <= mem_config_vaddr;
                bytes_left      <= mem_config_size;
                emit_left       <= mem_config_size;
                bytes_in_region <= mem_config_size[27:0];
                num_requests    <= '0;
                num_completed   <= '0;
            end else begin
                if (sq_hs) begin
                    vaddr        <= vaddr + VADDR_BITS'(req_len);
                    bytes_left   <= bytes_left - VADDR_BITS'(req_len);
                    num_requests <= num_requests + VADDR_BITS'(1);
                end
                if (cq_hit) num_completed <= num_completed + VADDR_BITS'(1);
                if (in_hs) emit_left <= region_last ? '0 : emit_left - VADDR_BITS'(BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sq_hs) len_fifo[wr_ptr] <= req_len;
    end

    // The length FIFO occupancy doubles as the outstanding-request count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
        end else begin
            if (sq_hs) wr_ptr <= wr_ptr + 4'd1;
            if (req_done) begin
                rd_ptr   <= rd_ptr + 4'd1;
                beat_cnt <= '0;
            end else if (in_hs) begin
                beat_cnt <= beat_cnt + LEN_BITS'(1);
            end
            case ({sq_hs, req_done})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign input_data_tready = !output_data_tvalid || output_data_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data_tvalid <= 1'b0;
            output_data_tdata  <= '0;
            output_data_tkeep  <= '0;
            output_data_tlast  <= 1'b0;
        end else if (input_data_tready) begin
            output_data_tvalid <= input_data_tvalid;
            if (input_data_tvalid) begin
                output_data_tdata <= input_data_tdata;
                output_data_tkeep <= beat_keep;
                output_data_tlast <= region_last;
            end
        end
    end

    a_data_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(input_data_tvalid && outstanding == 5'd0))
        else $fatal(1, "input data arrived with no outstanding request");
    a_region_too_large: assert property (@(posedge clk) disable iff (!rst_n)
        !(buf_hs && mem_config_size > VADDR_BITS'(28'hfff_ffff)))
        else $fatal(1, "region size exceeds 2^28-1 bytes");
endmodule
